// File: rtl/gamerom_pkg.sv
// Shared definitions for the game ROM loader: ROM geometry, pad byte and loader states.
package gamerom_pkg;

    localparam int         ROM_ADDR_W       = 14;
    localparam int         ROM_WORDS        = 1 << ROM_ADDR_W;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // 68k word order: the first byte of the stream lands in the upper half.
    function automatic logic [15:0] be_word(input logic [7:0] first_byte,
                                            input logic [7:0] second_byte);
        return {first_byte, second_byte};
    endfunction

endpackage

// File: rtl/gamerom_byte_packer.sv
// Holds the high byte of the word being assembled and forms the candidate ROM words.
module gamerom_byte_packer
    import gamerom_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hi_load_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] pair_word_o,
    output logic [15:0] held_pad_word_o,
    output logic [15:0] new_pad_word_o
);

    logic [7:0] hi_q;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
        end else if (hi_load_i) begin
            hi_q <= byte_i;
        end
    end

    assign pair_word_o     = be_word(hi_q, byte_i);
    assign held_pad_word_o = be_word(hi_q, PAD_BYTE);
    // A high byte that arrives together with load_end is padded straight away.
    assign new_pad_word_o  = be_word(byte_i, PAD_BYTE);

endmodule

// File: rtl/gamerom_loader.sv
// Game ROM write-port master: packs a byte stream into big-endian words, writes them
// at consecutive addresses, holds the CPU in reset meanwhile and tracks count/checksum.
module gamerom_loader
    import gamerom_pkg::*;
#(
    parameter int         ADDR_W    = ROM_ADDR_W,
    parameter int         MAX_WORDS = ROM_WORDS,
    parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              load_end,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [15:0]       din_b,
    output logic              loading,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [15:0]         sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic                load_q, load_d;
    logic                end_pend_q, end_pend_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         din_q, din_d;

    logic                accept;
    logic                full;
    logic                hi_load;
    logic [15:0]         pair_word;
    logic [15:0]         held_pad_word;
    logic [15:0]         new_pad_word;

    gamerom_byte_packer #(
        .PAD_BYTE(PAD_BYTE)
    ) u_packer (
        .clk            (clk),
        .resetn         (resetn),
        .hi_load_i      (hi_load),
        .byte_i         (byte_data),
        .pair_word_o    (pair_word),
        .held_pad_word_o(held_pad_word),
        .new_pad_word_o (new_pad_word)
    );

    assign byte_ready = (state_q == ST_HI) || (state_q == ST_LO);
    assign accept     = byte_valid && byte_ready;
    assign full       = (cnt_q == MAX_CNT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            load_q     <= 1'b0;
            end_pend_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            load_q     <= load_d;
            end_pend_q <= end_pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        load_d     = load_q;
        end_pend_d = end_pend_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        hi_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    ptr_d      = base_addr;
                    cnt_d      = '0;
                    sum_d      = '0;
                    ovf_d      = 1'b0;
                    load_d     = 1'b1;
                    end_pend_d = 1'b0;
                    state_d    = ST_HI;
                end
            end
            ST_HI: begin
                if (accept && full) begin
                    ovf_d = 1'b1;
                    if (load_end) state_d = ST_DONE;
                end else if (accept) begin
                    hi_load = 1'b1;
                    if (load_end) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        din_d   = new_pad_word;
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_LO;
                    end
                end else if (load_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_LO: begin
                if (accept) begin
                    we_d       = 1'b1;
                    addr_d     = ptr_q;
                    din_d      = pair_word;
                    end_pend_d = load_end;
                    state_d    = ST_WRITE;
                end else if (load_end) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    din_d   = held_pad_word;
                    state_d = ST_FLUSH;
                end
            end
            ST_WRITE, ST_FLUSH: begin
                // The word is on the ROM port this cycle; account for it.
                ptr_d      = ptr_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                sum_d      = sum_q + din_q;
                end_pend_d = 1'b0;
                if (state_q == ST_FLUSH || end_pend_q || load_end) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_DONE: begin
                load_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign we_b       = we_q;
    assign addr_b     = addr_q;
    assign din_b      = din_q;
    assign loading    = load_q;
    assign done       = (state_q == ST_DONE);
    assign overflow   = ovf_q;
    assign word_count = cnt_q;
    assign checksum   = sum_q;

endmodule

// File: tb/tb_gamerom_loader.sv
// Self-checking bench for gamerom_loader: directed scenarios plus randomized loads,
// each compared with a word-list model built from the byte stream.
module tb_gamerom_loader;

    localparam int ADDR_W    = 14;
    localparam int MAX_MAIN  = 16384;
    localparam int MAX_SMALL = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              load_end = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;

    logic              byte_ready_m, we_b_m, loading_m, done_m, overflow_m;
    logic [ADDR_W-1:0] addr_b_m;
    logic [15:0]       din_b_m, checksum_m;
    logic [ADDR_W:0]   word_count_m;

    logic              byte_ready_s, we_b_s, loading_s, done_s, overflow_s;
    logic [ADDR_W-1:0] addr_b_s;
    logic [15:0]       din_b_s, checksum_s;
    logic [ADDR_W:0]   word_count_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  tx_bytes[$];
    logic [29:0] wr_m[$];
    logic [29:0] wr_s[$];

    gamerom_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_MAIN), .PAD_BYTE(8'hFF)) dut_main (
        .clk(clk), .resetn(resetn), .load_start(load_start), .base_addr(base_addr),
        .load_end(load_end), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready_m), .we_b(we_b_m), .addr_b(addr_b_m), .din_b(din_b_m),
        .loading(loading_m), .done(done_m), .overflow(overflow_m),
        .word_count(word_count_m), .checksum(checksum_m)
    );

    gamerom_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_SMALL), .PAD_BYTE(8'hFF)) dut_small (
        .clk(clk), .resetn(resetn), .load_start(load_start), .base_addr(base_addr),
        .load_end(load_end), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready_s), .we_b(we_b_s), .addr_b(addr_b_s), .din_b(din_b_s),
        .loading(loading_s), .done(done_s), .overflow(overflow_s),
        .word_count(word_count_s), .checksum(checksum_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_b_m === 1'b1) wr_m.push_back({addr_b_m, din_b_m});
        if (we_b_s === 1'b1) wr_s.push_back({addr_b_s, din_b_s});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_ready(input int sel);
        return (sel != 0) ? byte_ready_s : byte_ready_m;
    endfunction
    function automatic logic g_we(input int sel);
        return (sel != 0) ? we_b_s : we_b_m;
    endfunction
    function automatic logic [ADDR_W-1:0] g_addr(input int sel);
        return (sel != 0) ? addr_b_s : addr_b_m;
    endfunction
    function automatic logic [15:0] g_din(input int sel);
        return (sel != 0) ? din_b_s : din_b_m;
    endfunction
    function automatic logic g_done(input int sel);
        return (sel != 0) ? done_s : done_m;
    endfunction
    function automatic logic g_loading(input int sel);
        return (sel != 0) ? loading_s : loading_m;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #2;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Drives one load from tx_bytes; optionally ends it and waits for done.
    task automatic run_load(input int sel, input logic [ADDR_W-1:0] base, input int gap_pct,
                            input bit simul, input bit do_end, input string tag);
        int n, k, stall, maxw, first_cyc, last_cyc;
        logic rdy;
        logic [ADDR_W-1:0] exp_addr;
        n = tx_bytes.size();
        k = 0;
        stall = 0;
        first_cyc = 0;
        last_cyc = 0;
        maxw = (sel != 0) ? MAX_SMALL : MAX_MAIN;
        wr_m.delete();
        wr_s.delete();
        @(posedge clk); #1;
        load_start = 1'b1;
        base_addr  = base;
        @(posedge clk); #1;
        load_start = 1'b0;
        check({tag, "_loading"}, g_loading(sel), 1'b1);
        while (k < n && stall < 60) begin
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = tx_bytes[k];
            rdy        = g_ready(sel);
            load_end   = simul && do_end && (k == n - 1) && byte_valid && rdy;
            @(posedge clk); #1;
            load_end = 1'b0;
            if (byte_valid && rdy) begin
                if (k == 0) first_cyc = cyc;
                last_cyc = cyc;
                if ((k % 2) == 1 && (k / 2) < maxw) begin
                    exp_addr = base + ADDR_W'(k / 2);
                    check({tag, "_we_latency"}, g_we(sel), 1'b1);
                    check({tag, "_ready_in_write"}, g_ready(sel), 1'b0);
                    check({tag, "_wr_addr"}, g_addr(sel), exp_addr);
                    check({tag, "_wr_data"}, g_din(sel), {tx_bytes[k - 1], tx_bytes[k]});
                end
                k++;
                stall = 0;
            end else begin
                stall++;
            end
        end
        byte_valid = 1'b0;
        check({tag, "_bytes_taken"}, k, n);
        if (gap_pct == 0 && n > 1 && (2 * maxw) >= n)
            check({tag, "_span"}, last_cyc - first_cyc, 3 * ((n - 1) / 2) + ((n - 1) % 2));
        if (do_end) begin
            if (!simul || n == 0) begin
                repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                load_end = 1'b1;
                @(posedge clk); #1;
                load_end = 1'b0;
            end
            stall = 0;
            while (g_done(sel) !== 1'b1 && stall < 40) begin
                @(posedge clk); #1;
                stall++;
            end
            check({tag, "_done_pulse"}, g_done(sel), 1'b1);
            @(posedge clk); #1;
            check({tag, "_done_once"}, g_done(sel), 1'b0);
            check({tag, "_loading_off"}, g_loading(sel), 1'b0);
        end
    endtask

    // Reference: pair bytes big-endian, pad a trailing byte, keep at most maxw words.
    task automatic verify(input int sel, input logic [ADDR_W-1:0] base, input string tag);
        int n, nw, got_n, maxw;
        logic [15:0] exp_word, sum;
        logic [7:0] lo;
        logic [29:0] got;
        logic [ADDR_W-1:0] exp_addr;
        n = tx_bytes.size();
        maxw = (sel != 0) ? MAX_SMALL : MAX_MAIN;
        nw = (n + 1) / 2;
        if (nw > maxw) nw = maxw;
        sum = '0;
        got_n = (sel != 0) ? wr_s.size() : wr_m.size();
        check({tag, "_n_writes"}, got_n, nw);
        for (int i = 0; i < nw; i++) begin
            lo = (2 * i + 1 < n) ? tx_bytes[2 * i + 1] : 8'hFF;
            exp_word = {tx_bytes[2 * i], lo};
            exp_addr = base + ADDR_W'(i);
            sum = sum + exp_word;
            if (i < got_n) begin
                got = (sel != 0) ? wr_s[i] : wr_m[i];
                check({tag, "_rom_addr"}, got[29:16], exp_addr);
                check({tag, "_rom_data"}, got[15:0], exp_word);
            end
        end
        check({tag, "_word_count"}, (sel != 0) ? word_count_s : word_count_m, nw);
        check({tag, "_checksum"}, (sel != 0) ? checksum_s : checksum_m, sum);
        check({tag, "_overflow"}, (sel != 0) ? overflow_s : overflow_m, (n > 2 * maxw));
    endtask

    initial begin
        logic [ADDR_W-1:0] rbase;
        int rn;
        #3;
        check("rst_we", we_b_m, 1'b0);
        check("rst_ready", byte_ready_m, 1'b0);
        check("rst_outputs", {loading_m, done_m, overflow_m, addr_b_m, din_b_m}, '0);
        check("rst_count_sum", {word_count_m, checksum_m}, '0);
        @(posedge clk); #1;
        resetn = 1'b1;

        tx_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(0, 14'h0000, 0, 1'b0, 1'b1, "basic");
        verify(0, 14'h0000, "basic");
        check("basic_sum_const", checksum_m, 16'h68AC);

        tx_bytes = '{8'hAB, 8'hCD, 8'hEF};
        run_load(0, 14'h0010, 0, 1'b0, 1'b1, "odd");
        verify(0, 14'h0010, "odd");

        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        run_load(0, 14'h0100, 0, 1'b0, 1'b1, "stream");
        verify(0, 14'h0100, "stream");

        tx_bytes = '{8'hC0, 8'hDE, 8'hBE, 8'hEF};
        run_load(0, 14'h0200, 0, 1'b1, 1'b1, "simul_lo");
        verify(0, 14'h0200, "simul_lo");

        tx_bytes = '{8'h11, 8'h22, 8'h33};
        run_load(0, 14'h0300, 0, 1'b1, 1'b1, "simul_hi");
        verify(0, 14'h0300, "simul_hi");

        tx_bytes = '{8'h11, 8'h22, 8'h33};
        run_load(0, 14'h0020, 0, 1'b0, 1'b0, "midrst");
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_we", we_b_m, 1'b0);
        check("midrst_outputs", {loading_m, done_m, overflow_m, addr_b_m, din_b_m, byte_ready_m}, '0);
        check("midrst_count_sum", {word_count_m, checksum_m}, '0);
        check("midrst_n_writes", wr_m.size(), 1);
        if (wr_m.size() > 0) check("midrst_word0", wr_m[0], {14'h0020, 16'h1122});
        @(posedge clk); #1;
        resetn = 1'b1;
        tx_bytes = '{8'h5A, 8'hA5};
        run_load(0, 14'h0040, 0, 1'b0, 1'b1, "after_rst");
        verify(0, 14'h0040, "after_rst");

        apply_reset();
        tx_bytes = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
        run_load(1, 14'h3FFF, 0, 1'b0, 1'b1, "wrap_ovf");
        verify(1, 14'h3FFF, "wrap_ovf");

        apply_reset();
        for (int t = 0; t < 10; t++) begin
            rn = $urandom_range(11);
            tx_bytes.delete();
            for (int i = 0; i < rn; i++) tx_bytes.push_back(8'($urandom));
            rbase = ADDR_W'($urandom);
            run_load(0, rbase, $urandom_range(40), 1'($urandom_range(1)), 1'b1, "rand");
            verify(0, rbase, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
